cmsdk_ahb_eg_fifo_regs: RTL and testbench
=========================================

Name: cmsdk_ahb_eg_fifo_regs

Overview:
- Register-mapped peripheral sitting directly downstream of the AHB example slave interface.
- Consumes its simple register protocol: addr, read_en, write_en, byte_strobe, wdata. Returns rdata.
- Contains a word-wide synchronous FIFO, status and control registers, and a level-threshold interrupt.
- Lets software stream data through the AHB example slave with push-on-write / pop-on-read semantics.

Parameters:
- ADDRWIDTH, 12, width of addr; must match the interface.
- FIFO_AW, 3, FIFO address bits; depth = 2**FIFO_AW (default 8 entries, 32 bits each).

Ports:
- hclk  input  1  clock
- hreset  input  1  synchronous reset, active-high
- addr  input  ADDRWIDTH  registered word address from the slave interface
- read_en  input  1  data-phase read strobe
- write_en  input  1  data-phase write strobe
- byte_strobe  input  4  byte lanes for the write
- wdata  input  32  write data, valid while write_en=1
- rdata  output  32  read data, combinational, valid in the same cycle as read_en
- irq  output  1  registered level interrupt

Behaviour:
- Decode uses addr[ADDRWIDTH-1:2]; addr[1:0] is ignored.
- Register map:
  - 0x000 DATA: write pushes; read pops.
  - 0x004 STATUS (RO): [0] empty, [1] full, [2] overflow (sticky), [3] underflow (sticky), [8+FIFO_AW:8] count 0..depth.
  - 0x008 CTRL (RW): [0] flush, self-clearing, reads 0; [1] irq_en; [15:8] threshold.
  - 0x00C INTCLR (WO): write 1 to bit 2 or bit 3 clears the matching sticky flag.
  - All other offsets read 0; writes to them are ignored.
- Reset (hreset=1 at posedge): FIFO empty, count=0, pointers=0, sticky flags=0, CTRL=0, irq=0. rdata=0 whenever read_en=0.
- Reset mid-operation drops all FIFO content; no partial state survives.
- Read timing:
  - rdata is driven combinationally from addr and state in the read_en cycle, for zero wait states (hreadyout is always 1).
  - Pop commits at the posedge ending that cycle.
- Push:
  - Occurs on write_en & DATA & !full.
  - Stored word = wdata with non-strobed byte lanes forced to 0.
  - Push while full: data dropped, overflow set, pointers unchanged.
- Pop:
  - Occurs on read_en & DATA & !empty; rdata = head word.
  - Pop while empty: rdata=0, underflow set, pointers unchanged.
- Push and pop in the same cycle are both honoured; count is unchanged. When full, the pop frees the slot and the push succeeds, with no overflow.
- CTRL/INTCLR writes honour byte_strobe per byte lane.
- Flush:
  - Write CTRL with bit 0 = 1 and byte_strobe[0]=1: pointers and count go to 0 at the next edge.
  - Sticky flags are kept.
  - Flush overrides a simultaneous push or pop.
- Sticky set and INTCLR clear in the same cycle: set wins.
- Pointers are FIFO_AW bits and wrap modulo depth. count has FIFO_AW+1 bits.
- irq is registered: irq_next = irq_en & ((count >= threshold & threshold != 0) | overflow | underflow). Latency is 1 cycle after the causing edge.
- Threshold is compared zero-extended; threshold > depth means the level term never fires.

Optional Feature:
- Macro: CMSDK_EG_FIFO_PEEK_EN.
- Defined: offset 0x010 PEEK (RO) returns the head word without popping. Returns 0 and sets no flag when empty.
- Undefined: 0x010 behaves as an unmapped offset (reads 0, no logic instantiated).

Decomposition:
- Package cmsdk_eg_fifo_pkg holds:
  - register offsets: DATA, STATUS, CTRL, INTCLR, PEEK
  - STATUS/CTRL bit-position constants
  - the byte-lane mask function
- Sub-module cmsdk_eg_sync_fifo:
  - parameterised storage and pointer/count logic
  - push/pop/flush inputs; full/empty/count/head outputs
  - synchronous active-high reset
- Top level keeps decode, control/status registers and irq.

Test Plan:
- Reset, then read STATUS -> rdata=0x00000001 (empty); irq=0.
- Push 0x11111111..0x88888888 (8 writes, strobe 4'b1111) -> STATUS=0x00000802 (full, count=8). A 9th push -> overflow set, STATUS=0x00000806. Then 8 DATA reads return 0x11111111..0x88888888 in order, each in the read_en cycle.
- Pop empty FIFO -> rdata=0, STATUS bit 3 set. Write INTCLR=0x8 -> bit 3 cleared next cycle.
- Push with byte_strobe=4'b0100, wdata=0xAABBCCDD -> popped word = 0x00BB0000.
- CTRL=0x0302 (irq_en, threshold=3). Push 3 words -> irq rises 1 cycle after the 3rd push edge. One pop -> irq falls 1 cycle later.
- Fill to 5 entries, write CTRL flush -> count=0, empty=1. Assert hreset mid-burst -> all state at reset values. With CMSDK_EG_FIFO_PEEK_EN: PEEK returns head; count unchanged.

Source files
------------

// File: rtl/cmsdk_eg_fifo_pkg.sv
// Shared register map, bit positions and helpers for the AHB example FIFO peripheral.
// Optional PEEK register is enabled by CMSDK_EG_FIFO_PEEK_EN (see cmsdk_ahb_eg_fifo_regs).
package cmsdk_eg_fifo_pkg;

    // Word indices (byte offset >> 2) of the register map.
    localparam int WORD_DATA   = 0;
    localparam int WORD_STATUS = 1;
    localparam int WORD_CTRL   = 2;
    localparam int WORD_INTCLR = 3;
    localparam int WORD_PEEK   = 4;

    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVF       = 2;
    localparam int ST_UDF       = 3;
    localparam int ST_COUNT_LSB = 8;

    localparam int CTRL_FLUSH   = 0;
    localparam int CTRL_IRQ_EN  = 1;
    localparam int CTRL_THR_LSB = 8;

    localparam int INTCLR_OVF = 2;
    localparam int INTCLR_UDF = 3;

    typedef struct packed {
        logic [7:0] thr;
        logic       irq_en;
    } ctrl_t;

    function automatic logic [31:0] byte_lane_mask(input logic [3:0] strobe);
        logic [31:0] mask;
        for (int i = 0; i < 4; i++) begin
            mask[i*8 +: 8] = {8{strobe[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/cmsdk_ahb_eg_fifo_regs_if.sv
// Register-access bus between the AHB example slave interface and its register block.
interface cmsdk_ahb_eg_fifo_regs_if #(
    parameter int ADDRWIDTH = 12
);
    // read_en/write_en are single-cycle data-phase strobes; the slave never stalls
    // (implicit ready=1), so each asserted strobe is one complete transfer, and
    // rdata is valid combinationally in the same cycle as read_en.
    logic [ADDRWIDTH-1:0] addr;
    logic                 read_en;
    logic                 write_en;
    logic [3:0]           byte_strobe;
    logic [31:0]          wdata;
    logic [31:0]          rdata;

    modport master (
        output addr, read_en, write_en, byte_strobe, wdata,
        input  rdata
    );

    modport slave (
        input  addr, read_en, write_en, byte_strobe, wdata,
        output rdata
    );
endinterface

// File: rtl/cmsdk_eg_sync_fifo.sv
// Word-wide synchronous FIFO: storage, wrapping pointers and occupancy count.
// Flush has priority over push/pop; caller guarantees push is only issued when space exists.
module cmsdk_eg_sync_fifo #(
    parameter int AW = 3,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [DW-1:0] wdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic [DW-1:0] head
);
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/cmsdk_ahb_eg_fifo_regs.sv
// FIFO register block behind the AHB example slave: push-on-write / pop-on-read DATA,
// STATUS, CTRL, INTCLR and a level interrupt. Define CMSDK_EG_FIFO_PEEK_EN to add PEEK at 0x010.
module cmsdk_ahb_eg_fifo_regs
    import cmsdk_eg_fifo_pkg::*;
#(
    parameter int ADDRWIDTH = 12,
    parameter int FIFO_AW   = 3
) (
    input  logic                     hclk,
    input  logic                     hreset,
    cmsdk_ahb_eg_fifo_regs_if.slave  bus,
    output logic                     irq
);
    localparam int WW = ADDRWIDTH - 2;

    logic [WW-1:0] word;
    logic          sel_data, sel_status, sel_ctrl, sel_intclr;
    logic          data_wr, data_rd, ctrl_wr, intclr_wr;
    logic          do_push, do_pop, flush, ovf_evt, udf_evt;
    logic          unused_addr_bits;

    logic              fifo_full, fifo_empty;
    logic [FIFO_AW:0]  fifo_count;
    logic [31:0]       fifo_head;
    logic [31:0]       status;
    logic              level_hit;

    logic  ovf_q, ovf_d;
    logic  udf_q, udf_d;
    ctrl_t ctrl_q, ctrl_d;
    logic  irq_q, irq_d;

    // Byte offset bits are not part of the decode.
    assign word             = bus.addr[ADDRWIDTH-1:2];
    assign unused_addr_bits = ^bus.addr[1:0];

    assign sel_data   = (word == WW'(WORD_DATA));
    assign sel_status = (word == WW'(WORD_STATUS));
    assign sel_ctrl   = (word == WW'(WORD_CTRL));
    assign sel_intclr = (word == WW'(WORD_INTCLR));

    assign data_wr   = bus.write_en & sel_data;
    assign data_rd   = bus.read_en  & sel_data;
    assign ctrl_wr   = bus.write_en & sel_ctrl;
    assign intclr_wr = bus.write_en & sel_intclr;

    // A pop in the same cycle frees the slot, so a push into a full FIFO still succeeds.
    assign do_pop  = data_rd & ~fifo_empty;
    assign do_push = data_wr & (~fifo_full | do_pop);
    assign ovf_evt = data_wr & fifo_full & ~do_pop;
    assign udf_evt = data_rd & fifo_empty;
    assign flush   = ctrl_wr & bus.byte_strobe[0] & bus.wdata[CTRL_FLUSH];

    cmsdk_eg_sync_fifo #(
        .AW (FIFO_AW),
        .DW (32)
    ) u_fifo (
        .clk   (hclk),
        .rst   (hreset),
        .push  (do_push),
        .pop   (do_pop),
        .flush (flush),
        .wdata (bus.wdata & byte_lane_mask(bus.byte_strobe)),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count),
        .head  (fifo_head)
    );

    always_comb begin
        ovf_d  = ovf_q;
        udf_d  = udf_q;
        ctrl_d = ctrl_q;
        if (intclr_wr && bus.byte_strobe[0]) begin
            if (bus.wdata[INTCLR_OVF]) ovf_d = 1'b0;
            if (bus.wdata[INTCLR_UDF]) udf_d = 1'b0;
        end
        // Set is applied after clear so a coincident event is never lost.
        if (ovf_evt) ovf_d = 1'b1;
        if (udf_evt) udf_d = 1'b1;
        if (ctrl_wr) begin
            if (bus.byte_strobe[0]) ctrl_d.irq_en = bus.wdata[CTRL_IRQ_EN];
            if (bus.byte_strobe[1]) ctrl_d.thr    = bus.wdata[CTRL_THR_LSB +: 8];
        end
        level_hit = (ctrl_q.thr != 8'd0) && (32'(fifo_count) >= 32'(ctrl_q.thr));
        irq_d     = ctrl_q.irq_en & (level_hit | ovf_q | udf_q);
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
            ctrl_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            ovf_q  <= ovf_d;
            udf_q  <= udf_d;
            ctrl_q <= ctrl_d;
            irq_q  <= irq_d;
        end
    end

    assign irq = irq_q;

    always_comb begin
        status                               = '0;
        status[ST_EMPTY]                     = fifo_empty;
        status[ST_FULL]                      = fifo_full;
        status[ST_OVF]                       = ovf_q;
        status[ST_UDF]                       = udf_q;
        status[ST_COUNT_LSB +: FIFO_AW + 1]  = fifo_count;
    end

    always_comb begin
        bus.rdata = '0;
        if (bus.read_en) begin
            if (sel_data && !fifo_empty) begin
                bus.rdata = fifo_head;
            end else if (sel_status) begin
                bus.rdata = status;
            end else if (sel_ctrl) begin
                bus.rdata[CTRL_IRQ_EN]         = ctrl_q.irq_en;
                bus.rdata[CTRL_THR_LSB +: 8]   = ctrl_q.thr;
            end
`ifdef CMSDK_EG_FIFO_PEEK_EN
            if ((word == WW'(WORD_PEEK)) && !fifo_empty) begin
                bus.rdata = fifo_head;
            end
`endif
        end
    end

endmodule

// File: tb/tb_cmsdk_ahb_eg_fifo_regs.sv
// Self-checking bench for cmsdk_ahb_eg_fifo_regs: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based reference model.
module tb_cmsdk_ahb_eg_fifo_regs;

    localparam int DEPTH = 8;

    logic hclk = 1'b0;
    logic hreset;
    logic irq;

    cmsdk_ahb_eg_fifo_regs_if #(.ADDRWIDTH(12)) bus ();

    cmsdk_ahb_eg_fifo_regs #(
        .ADDRWIDTH (12),
        .FIFO_AW   (3)
    ) dut (
        .hclk   (hclk),
        .hreset (hreset),
        .bus    (bus),
        .irq    (irq)
    );

    always #5 hclk = ~hclk;

    // ---------------- scoreboard / counters ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, got, exp);
    endtask

    // ---------------- reference model ----------------
    logic [31:0] exp_q[$];
    bit          m_ovf, m_udf, m_irq_en;
    int          m_thr;

`ifdef CMSDK_EG_FIFO_PEEK_EN
    localparam bit PEEK_ON = 1'b1;
`else
    localparam bit PEEK_ON = 1'b0;
`endif

    function automatic logic [31:0] lane_mask(input logic [3:0] s);
        logic [31:0] m = 0;
        for (int i = 0; i < 4; i++) if (s[i]) m = m | (32'hFF << (8 * i));
        return m;
    endfunction

    function automatic logic [31:0] model_read(input logic [11:0] a);
        int w  = int'(a[11:2]);
        int sz = exp_q.size();
        int st = 0;
        case (w)
            0: return (sz > 0) ? exp_q[0] : 32'h0;
            1: begin
                if (sz == 0)     st += 1;
                if (sz == DEPTH) st += 2;
                if (m_ovf)       st += 4;
                if (m_udf)       st += 8;
                st += sz * 256;
                return 32'(st);
            end
            2: return 32'(m_thr * 256 + (m_irq_en ? 2 : 0));
            4: return (PEEK_ON && sz > 0) ? exp_q[0] : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_ovf = 0; m_udf = 0; m_irq_en = 0; m_thr = 0;
    endtask

    // Expected rdata/irq come from the state before the edge; state then advances.
    task automatic model_step(input bit we, input bit re, input logic [11:0] a,
                              input logic [3:0] s, input logic [31:0] d,
                              output logic [31:0] e_rd, output logic e_irq);
        int w = int'(a[11:2]);
        e_rd  = re ? model_read(a) : 32'h0;
        e_irq = m_irq_en && ((m_thr != 0 && exp_q.size() >= m_thr) || m_ovf || m_udf);
        if (re && w == 0) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            else m_udf = 1;
        end
        if (we) begin
            case (w)
                0: if (exp_q.size() < DEPTH) exp_q.push_back(d & lane_mask(s));
                   else m_ovf = 1;
                2: begin
                    if (s[0]) begin
                        if (d[0]) exp_q.delete();
                        m_irq_en = d[1];
                    end
                    if (s[1]) m_thr = int'(d[15:8]);
                end
                3: if (s[0]) begin
                    if (d[2]) m_ovf = 0;
                    if (d[3]) m_udf = 0;
                end
                default: ;
            endcase
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic bus_cycle(input bit rst, input bit we, input bit re, input logic [11:0] a,
                             input logic [3:0] s, input logic [31:0] d,
                             output logic [31:0] rd, output logic irq_s);
        @(negedge hclk);
        hreset          = rst;
        bus.write_en    = we;
        bus.read_en     = re;
        bus.addr        = a;
        bus.byte_strobe = s;
        bus.wdata       = d;
        #1 rd = bus.rdata;
        @(posedge hclk);
        #1 irq_s = irq;
        hreset       = 1'b0;
        bus.write_en = 1'b0;
        bus.read_en  = 1'b0;
    endtask

    task automatic xact(input bit we, input bit re, input logic [11:0] a,
                        input logic [3:0] s, input logic [31:0] d,
                        output logic [31:0] got_rd, output logic got_irq,
                        output logic [31:0] e_rd, output logic e_irq);
        model_step(we, re, a, s, d, e_rd, e_irq);
        bus_cycle(1'b0, we, re, a, s, d, got_rd, got_irq);
    endtask

    task automatic do_reset();
        logic [31:0] rd;
        logic        ir;
        bus_cycle(1'b1, 1'b0, 1'b0, 12'h0, 4'h0, 32'h0, rd, ir);
        bus_cycle(1'b1, 1'b0, 1'b0, 12'h0, 4'h0, 32'h0, rd, ir);
        model_reset();
        check("reset_irq", {31'b0, ir}, 32'h0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          we;
        bit          re;
        logic [11:0] addr;
        logic [3:0]  strobe;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        bit          exp_irq;
    } vec_t;

    vec_t vecs[$];

    function automatic void vw(input logic [11:0] a, input logic [3:0] s, input logic [31:0] d, input bit ei);
        vecs.push_back('{1'b1, 1'b0, a, s, d, 32'h0, ei});
    endfunction
    function automatic void vr(input logic [11:0] a, input logic [31:0] er, input bit ei);
        vecs.push_back('{1'b0, 1'b1, a, 4'h0, 32'h0, er, ei});
    endfunction
    function automatic void vi(input bit ei);
        vecs.push_back('{1'b0, 1'b0, 12'h0, 4'h0, 32'h0, 32'h0, ei});
    endfunction

    function automatic void build_table();
        vr(12'h004, 32'h0000_0001, 0);
        for (int k = 1; k <= 8; k++) vw(12'h000, 4'hF, 32'h1111_1111 * k, 0);
        vr(12'h004, 32'h0000_0802, 0);
        vw(12'h000, 4'hF, 32'h9999_9999, 0);
        vr(12'h004, 32'h0000_0806, 0);
        for (int k = 1; k <= 8; k++) vr(12'h000, 32'h1111_1111 * k, 0);
        vr(12'h004, 32'h0000_0005, 0);
        vr(12'h000, 32'h0000_0000, 0);
        vr(12'h004, 32'h0000_000D, 0);
        vw(12'h00C, 4'hF, 32'h8, 0);
        vr(12'h004, 32'h0000_0005, 0);
        vw(12'h00C, 4'hF, 32'h4, 0);
        vr(12'h004, 32'h0000_0001, 0);
        vw(12'h000, 4'b0100, 32'hAABB_CCDD, 0);
        vr(12'h000, 32'h00BB_0000, 0);
        // Threshold interrupt: irq_en, threshold 3.
        vw(12'h008, 4'hF, 32'h0000_0302, 0);
        vr(12'h008, 32'h0000_0302, 0);
        vw(12'h000, 4'hF, 32'hA000_0001, 0);
        vw(12'h000, 4'hF, 32'hA000_0002, 0);
        vw(12'h000, 4'hF, 32'hA000_0003, 0);
        vi(1);
        vr(12'h000, 32'hA000_0001, 1);
        vi(0);
        vr(12'h004, 32'h0000_0200, 0);
        vw(12'h000, 4'hF, 32'hA000_0004, 0);
        vw(12'h000, 4'hF, 32'hA000_0005, 1);
        vw(12'h000, 4'hF, 32'hA000_0006, 1);
        vr(12'h004, 32'h0000_0500, 1);
        // Flush with 5 entries; irq_en and threshold rewritten unchanged.
        vw(12'h008, 4'hF, 32'h0000_0303, 1);
        vr(12'h004, 32'h0000_0001, 0);
        vr(12'h008, 32'h0000_0302, 0);
        // Threshold beyond depth: only the overflow term can raise irq.
        vw(12'h008, 4'hF, 32'h0000_0902, 0);
        for (int k = 0; k < 8; k++) vw(12'h000, 4'hF, 32'hC0DE_0000 + k, 0);
        vr(12'h004, 32'h0000_0802, 0);
        vw(12'h000, 4'hF, 32'hDEAD_BEEF, 0);
        vr(12'h004, 32'h0000_0806, 1);
        vw(12'h00C, 4'hF, 32'h4, 1);
        vr(12'h004, 32'h0000_0802, 0);
        vw(12'h008, 4'hF, 32'h0000_0001, 0);
        vr(12'h004, 32'h0000_0001, 0);
        vr(12'h008, 32'h0000_0000, 0);
        // CTRL byte lanes.
        vw(12'h008, 4'b0010, 32'h0000_0500, 0);
        vr(12'h008, 32'h0000_0500, 0);
        vw(12'h008, 4'b0001, 32'h0000_0F02, 0);
        vr(12'h008, 32'h0000_0502, 0);
        vw(12'h008, 4'hF, 32'h0, 0);
        // INTCLR honours lane 0 only.
        vr(12'h000, 32'h0, 0);
        vw(12'h00C, 4'b0010, 32'h8, 0);
        vr(12'h004, 32'h0000_0009, 0);
        vw(12'h00C, 4'b0001, 32'h8, 0);
        vr(12'h004, 32'h0000_0001, 0);
        // PEEK / low address bits / unmapped.
        vw(12'h000, 4'hF, 32'h1234_5678, 0);
        vr(12'h010, PEEK_ON ? 32'h1234_5678 : 32'h0, 0);
        vr(12'h006, 32'h0000_0100, 0);
        vr(12'h000, 32'h1234_5678, 0);
        vr(12'h020, 32'h0, 0);
        vw(12'h020, 4'hF, 32'hFFFF_FFFF, 0);
        vr(12'h004, 32'h0000_0001, 0);
    endfunction

    // ---------------- stimulus ----------------
    logic [31:0] got_rd, e_rd;
    logic        got_irq, e_irq;

    initial begin
        hreset          = 1'b1;
        bus.addr        = '0;
        bus.read_en     = 1'b0;
        bus.write_en    = 1'b0;
        bus.byte_strobe = '0;
        bus.wdata       = '0;

        do_reset();

        build_table();
        for (int i = 0; i < vecs.size(); i++) begin
            xact(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].strobe, vecs[i].wdata,
                 got_rd, got_irq, e_rd, e_irq);
            check($sformatf("tbl%0d_rdata", i), got_rd, vecs[i].exp_rd);
            check($sformatf("tbl%0d_irq", i), {31'b0, got_irq}, {31'b0, vecs[i].exp_irq});
        end

        // Full FIFO with simultaneous push and pop: head returned, no overflow.
        for (int k = 0; k < 8; k++) xact(1, 0, 12'h000, 4'hF, 32'h5000_0000 + k, got_rd, got_irq, e_rd, e_irq);
        xact(1, 1, 12'h000, 4'hF, 32'h5000_0008, got_rd, got_irq, e_rd, e_irq);
        check("full_pushpop_rdata", got_rd, 32'h5000_0000);
        xact(0, 1, 12'h004, 4'h0, 32'h0, got_rd, got_irq, e_rd, e_irq);
        check("full_pushpop_status", got_rd, 32'h0000_0802);
        xact(0, 1, 12'h000, 4'h0, 32'h0, got_rd, got_irq, e_rd, e_irq);
        check("full_pushpop_head", got_rd, 32'h5000_0001);

        // Reset asserted mid-burst with irq armed and a push in flight.
        xact(1, 0, 12'h008, 4'hF, 32'h0000_0102, got_rd, got_irq, e_rd, e_irq);
        xact(0, 0, 12'h000, 4'h0, 32'h0, got_rd, got_irq, e_rd, e_irq);
        check("pre_rst_irq", {31'b0, got_irq}, 32'h1);
        bus_cycle(1'b1, 1'b1, 1'b0, 12'h000, 4'hF, 32'h7777_7777, got_rd, got_irq);
        model_reset();
        check("mid_rst_irq", {31'b0, got_irq}, 32'h0);
        xact(0, 1, 12'h004, 4'h0, 32'h0, got_rd, got_irq, e_rd, e_irq);
        check("mid_rst_status", got_rd, 32'h0000_0001);
        xact(0, 1, 12'h008, 4'h0, 32'h0, got_rd, got_irq, e_rd, e_irq);
        check("mid_rst_ctrl", got_rd, 32'h0);
        xact(0, 1, 12'h000, 4'h0, 32'h0, got_rd, got_irq, e_rd, e_irq);
        check("mid_rst_data", got_rd, 32'h0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            int          r    = $urandom_range(0, 99);
            int          kind = $urandom_range(0, 9);
            logic [11:0] a;
            logic [3:0]  s    = 4'($urandom_range(0, 15));
            logic [31:0] d    = $urandom;
            bit          we, re;
            if      (r < 45) a = 12'h000;
            else if (r < 60) a = 12'h004;
            else if (r < 72) a = 12'h008;
            else if (r < 82) a = 12'h00C;
            else if (r < 90) a = 12'h010;
            else             a = 12'($urandom_range(5, 1023) * 4);
            a[1:0] = 2'($urandom_range(0, 3));
            if (a[11:2] == 10'd0 && $urandom_range(0, 3) != 0) s = 4'hF;
            if (a[11:2] == 10'd2) begin
                d[0]    = ($urandom_range(0, 3) == 0);
                d[15:8] = 8'($urandom_range(0, 10));
            end
            we = (kind <= 3) || (kind == 8);
            re = (kind >= 4 && kind <= 8);
            xact(we, re, a, s, d, got_rd, got_irq, e_rd, e_irq);
            check($sformatf("rnd%0d_rdata", i), got_rd, e_rd);
            check($sformatf("rnd%0d_irq", i), {31'b0, got_irq}, {31'b0, e_irq});
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
